ahb_lite3_sram_responder: RTL
=============================

Name: ahb_lite3_sram_responder

Overview:
AHB-Lite3 slave (responder) that terminates one core bus port (iBus or dBus) of the top-level and serves it from an on-chip word-organised SRAM. It sits on the far end of the core's AHB-Lite3 master ports. It is instantiated once per bus, or behind a trivial decoder via HSEL. It inserts a configurable number of wait states and returns a two-cycle ERROR response for illegal accesses.

Parameters:
DEPTH_LOG2, 12, memory depth in 32-bit words (4096 words = 16 KiB)
BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2^DEPTH_LOG2
WAIT_STATES, 0, extra HREADYOUT=0 cycles per OKAY data phase (0..15)

Ports:
clk  in  1  clock
rst  in  1  reset
HSEL  in  1  slave select
HADDR  in  32  byte address (address phase)
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = half, 2 = word
HBURST  in  3  ignored (each beat is handled as a single transfer)
HPROT  in  4  ignored
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HMASTLOCK  in  1  ignored
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-level ready; when connected directly, tie to HREADYOUT
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset: one clock, rst; reset is synchronous and active-low.
  - rst=0 at a clk edge forces: state ADDR, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0, pending write cleared.
  - Memory contents are not cleared.
  - Reset mid-transfer abandons the transfer; no partial write is committed.
- Accept condition: HSEL & HREADY & HTRANS[1], sampled at a clk edge. On accept, register addr, size, write, and byte-enables.
- IDLE, BUSY, or unselected cycles with HREADY=1: next data phase is zero-wait OKAY. HRDATA holds its previous value.
- Error check at accept. The access is an error if any of these hold:
  - HSIZE > 2
  - HSIZE=1 and HADDR[0]=1
  - HSIZE=2 and HADDR[1:0]≠0
  - HADDR outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2)
- Byte enables (little-endian):
  - byte: 1 << HADDR[1:0]
  - half: 4'b0011 << HADDR[1:0]
  - word: 4'b1111
- FSM states: ADDR, WAIT, ERR1, ERR2.
  - ADDR: HREADYOUT=1, HRESP=0.
    - Legal accept with WAIT_STATES=0 stays in ADDR.
    - Legal accept with WAIT_STATES>0 goes to WAIT, counter=WAIT_STATES.
    - Illegal accept goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Decrement the counter; leave for ADDR on the cycle it reaches 0.
    - Legal transfer latency is therefore exactly WAIT_STATES+1 cycles after the accept edge.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, then return to ADDR.
    - A new accept in ERR2 is processed as in ADDR.
    - If the master drives IDLE during ERR1 (cancel), ERR2 is still completed.
- Write: HWDATA is sampled on the data-phase cycle with HREADYOUT=1. It is committed to memory at that edge, under byte enables.
  - Errored writes never modify memory.
- Read: HRDATA is valid in the data-phase cycle with HREADYOUT=1 and is held until the next read completes.
  - HRDATA for errored reads is 32'h0.
- Read-after-write forwarding: a read accepted on the same edge that commits a write to the same word must return the merged bytes (new bytes under the write's byte enables, old bytes elsewhere), for any WAIT_STATES.
- Back-to-back NONSEQ/SEQ with WAIT_STATES=0: sustained throughput of one transfer per cycle.
- Memory index: (HADDR - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits. The top word of the window is legal; the address one past it is an error.

Decomposition:
- Package ahb_lite3_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ localparams
  - HSIZE_BYTE/HALF/WORD
  - HRESP_OKAY/ERROR
  - resp_state_e enum {ADDR, WAIT, ERR1, ERR2}
  - function be_from_size(size, addr_lo)
- Sub-module ahb_sram_bytelane_mem: 2^DEPTH_LOG2 x 32 array with 4-bit write enable, synchronous write, registered read.
- Forwarding and the FSM live in the top of this block.

Test Plan:
- WAIT_STATES=0: word write 32'hDEAD_BEEF to BASE+0x10, then read BASE+0x10 -> HREADYOUT stays 1, HRESP=0, HRDATA=32'hDEAD_BEEF in the read data phase.
- Byte write 8'hA5 to BASE+0x13 over word 32'h1122_3344, immediately followed by a back-to-back read of BASE+0x10 -> HRDATA=32'hA522_3344 (forwarding path).
- WAIT_STATES=3: word read -> exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with data; total 4 cycles.
- Half-word access at BASE+0x01 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged; HRDATA=0.
- Read of BASE + 4*2^DEPTH_LOG2 -> ERROR; read of BASE + 4*2^DEPTH_LOG2 - 4 -> OKAY.
- Assert rst=0 during WAIT of a write with WAIT_STATES=2 -> next edge HREADYOUT=1, HRESP=0; the target word retains its old value.

Source files
------------

// File: rtl/ahb_lite3_pkg.sv
// ahb_lite3_pkg: shared AHB-Lite3 encodings, responder state type and byte-enable helper
package ahb_lite3_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'd0;
  localparam logic [1:0] HTRANS_BUSY = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ = 2'd3;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {ADDR, WAIT, ERR1, ERR2} resp_state_e;
  function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addrLo);
    return size == HSIZE_BYTE ? 4'b0001 << addrLo : size == HSIZE_HALF ? 4'b0011 << addrLo : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_sram_bytelane_mem.sv
// ahb_sram_bytelane_mem: word SRAM with per-byte write enables and registered read
module ahb_sram_bytelane_mem #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] wIdx,
  input  logic [31:0]           wData,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] rIdx,
  output logic [31:0]           rData
);
  logic [31:0] mem [2**DEPTH_LOG2];
  // byte-lane writes; the read returns the word as it was before this edge's write
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we[i]) mem[wIdx][i*8 +: 8] <= wData[i*8 +: 8];
    if (re) rData <= mem[rIdx];
  end
endmodule

// File: rtl/ahb_lite3_sram_responder.sv
// ahb_lite3_sram_responder: AHB-Lite3 responder serving a word SRAM with wait states and ERROR responses
module ahb_lite3_sram_responder
  import ahb_lite3_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int AW = DEPTH_LOG2;
  resp_state_e state, nextState;
  logic [3:0] waitCnt;
  logic dpValid, dpWrite, fwdHit;
  logic [AW-1:0] dpIdx, idx;
  logic [3:0] dpBe;
  logic [31:0] fwdData, fwdMask, rdHold, memRdata, merged, offset;
  logic accept, legal, readyOut, commit, readDone;
  logic unusedIn;
  assign unusedIn = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
  // address decode, legality and data-phase completion strobes
  always_comb begin
    offset = HADDR - BASE_ADDR;
    idx = offset[AW+1:2];
    accept = HSEL & HREADY & HTRANS[1] & readyOut;
    legal = HSIZE <= HSIZE_WORD && !(HSIZE == HSIZE_HALF && HADDR[0]) &&
            !(HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) && (offset >> (AW + 2)) == 32'd0;
    commit = dpValid & dpWrite & readyOut;
    readDone = dpValid & ~dpWrite & readyOut;
    merged = fwdHit ? (memRdata & ~fwdMask) | (fwdData & fwdMask) : memRdata;
  end
  // state register
  always_ff @(posedge clk) state <= !rst ? ADDR : nextState;
  // next-state: wait countdown, two-cycle error, otherwise react to a new accept
  always_comb begin
    nextState = state;
    if (state == WAIT) nextState = waitCnt == 4'd1 ? ADDR : WAIT;
    else if (state == ERR1) nextState = ERR2;
    else nextState = !accept ? ADDR : !legal ? ERR1 : WAIT_STATES > 0 ? WAIT : ADDR;
  end
  // bus response outputs decoded from state
  always_comb begin
    readyOut = state == ADDR || state == ERR2;
    HRESP = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end
  assign HREADYOUT = readyOut;
  assign HRDATA = readDone ? merged : rdHold;
  // data-phase bookkeeping, read hold register and same-edge write forwarding capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      waitCnt <= '0;
      dpValid <= 1'b0;
      dpWrite <= 1'b0;
      dpIdx <= '0;
      dpBe <= '0;
      fwdHit <= 1'b0;
      fwdData <= '0;
      fwdMask <= '0;
      rdHold <= '0;
    end else begin
      if (state == WAIT) waitCnt <= waitCnt - 4'd1;
      if (readDone) rdHold <= merged;
      if (readyOut) begin
        dpValid <= accept & legal;
        dpWrite <= HWRITE;
        dpIdx <= idx;
        dpBe <= be_from_size(HSIZE, HADDR[1:0]);
        if (accept & legal) waitCnt <= 4'(WAIT_STATES);
        if (accept & ~legal & ~HWRITE) rdHold <= '0;
        if (accept & legal & ~HWRITE) begin
          fwdHit <= commit && dpIdx == idx;
          fwdData <= HWDATA;
          fwdMask <= {{8{dpBe[3]}}, {8{dpBe[2]}}, {8{dpBe[1]}}, {8{dpBe[0]}}};
        end
      end
    end
  end
  ahb_sram_bytelane_mem #(.DEPTH_LOG2(AW)) mem (
    .clk(clk),
    .we({4{commit & rst}} & dpBe),
    .wIdx(dpIdx),
    .wData(HWDATA),
    .re(accept & legal & ~HWRITE),
    .rIdx(idx),
    .rData(memRdata)
  );
endmodule
